// File: rtl/wb_spi_pkg.sv
// Shared register map, STATUS bit positions and shift-engine state encoding.
package wb_spi_pkg;

  localparam logic [1:0] ADR_TXRX   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_DIV    = 2'd2;
  localparam logic [1:0] ADR_CS     = 2'd3;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_OVR  = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_TRAIL = 2'd2
  } spi_state_e;

endpackage

// File: rtl/wb_spi_master_ctrl_engine.sv
// SPI mode-0 byte shifter: divider, bit counter, shift register and phase FSM.
module spi_shift_engine
  import wb_spi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] div_i,
  input  logic [7:0] tx_i,
  output logic [7:0] rx_o,
  output logic       busy_o,
  output logic       done_pulse_o,
  output logic       sck_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  spi_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_q, rx_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rx_q    <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
    end
  end

  // Next-state: each phase lasts div+1 cycles; sample on rise, present next bit on fall.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    rx_d         = rx_q;
    sck_d        = sck_q;
    mosi_d       = mosi_q;
    done_pulse_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LEAD;
          div_d   = div_i;
          cnt_d   = div_i;
          bit_d   = '0;
          shift_d = tx_i;
          mosi_d  = tx_i[7];
          sck_d   = 1'b0;
        end
      end
      S_LEAD: begin
        if (cnt_q == '0) begin
          state_d = S_TRAIL;
          cnt_d   = div_q;
          sck_d   = 1'b1;
          shift_d = {shift_q[6:0], miso_i};
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_TRAIL: begin
        if (cnt_q == '0) begin
          sck_d = 1'b0;
          cnt_d = div_q;
          if (bit_q == 3'd7) begin
            state_d      = S_IDLE;
            rx_d         = shift_q;
            done_pulse_o = 1'b1;
          end else begin
            state_d = S_LEAD;
            bit_d   = bit_q + 3'd1;
            mosi_d  = shift_q[7];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_o   = rx_q;
  assign busy_o = (state_q != S_IDLE);
  assign sck_o  = sck_q;
  assign mosi_o = mosi_q;

endmodule

// File: rtl/wb_spi_master_ctrl.sv
// Wishbone classic slave wrapper: register decode, DIV/CS/status registers around the shift engine.
module wb_spi_master_ctrl
  import wb_spi_pkg::*;
#(
  parameter logic [7:0] DIV_RESET = 8'd11,
  parameter logic       CS_RESET  = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        spi_sck_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic        spi_cs0_o
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  div_q, div_d;
  logic        cs_q, cs_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;

  logic        acc;
  logic        start;
  logic        busy;
  logic        done_pulse;
  logic [7:0]  rx;
  logic        unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_dat_i[31:8]};

  assign acc   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign start = acc & wb_we_i & (wb_adr_i == ADR_TXRX) & ~busy;

  spi_shift_engine u_engine (
    .clk_i        (wb_clk_i),
    .rst_ni       (wb_rst_n_i),
    .start_i      (start),
    .div_i        (div_q),
    .tx_i         (wb_dat_i[7:0]),
    .rx_o         (rx),
    .busy_o       (busy),
    .done_pulse_o (done_pulse),
    .sck_o        (spi_sck_o),
    .mosi_o       (spi_mosi_o),
    .miso_i       (spi_miso_i)
  );

  // Bus and control registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      div_q  <= DIV_RESET;
      cs_q   <= CS_RESET;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      div_q  <= div_d;
      cs_q   <= cs_d;
      done_q <= done_d;
      ovr_q  <= ovr_d;
    end
  end

  // Register decode; side effects land on the ack edge. Done-set is applied last so it wins over a read-clear.
  always_comb begin
    ack_d  = acc;
    dat_d  = '0;
    div_d  = div_q;
    cs_d   = cs_q;
    done_d = done_q;
    ovr_d  = ovr_q;
    if (acc) begin
      unique case (wb_adr_i)
        ADR_TXRX: begin
          if (wb_we_i) begin
            if (busy) ovr_d = 1'b1;
            else      done_d = 1'b0;
          end else begin
            dat_d  = {24'b0, rx};
            done_d = 1'b0;
          end
        end
        ADR_STATUS: begin
          if (wb_we_i) begin
            if (wb_dat_i[ST_OVR]) ovr_d = 1'b0;
          end else begin
            dat_d = {29'b0, ovr_q, done_q, busy};
          end
        end
        ADR_DIV: begin
          if (wb_we_i) div_d = wb_dat_i[7:0];
          else         dat_d = {24'b0, div_q};
        end
        default: begin
          if (wb_we_i) cs_d  = wb_dat_i[0];
          else         dat_d = {31'b0, cs_q};
        end
      endcase
    end
    if (done_pulse) done_d = 1'b1;
  end

  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_q;
  assign spi_cs0_o = cs_q;

endmodule

// File: tb/tb_wb_spi_master_ctrl.sv
// Self-checking bench for wb_spi_master_ctrl: directed and randomized transfers against a timing/data model.
module tb_wb_spi_master_ctrl;
  import wb_spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        we;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        sck;
  logic        mosi;
  logic        miso;
  logic        cs0;

  always #5 clk = ~clk;

  wb_spi_master_ctrl #(.DIV_RESET(8'd11), .CS_RESET(1'b1)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat_w),
    .wb_dat_o   (dat_r),
    .wb_we_i    (we),
    .wb_sel_i   (sel),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_ack_o   (ack),
    .spi_sck_o  (sck),
    .spi_mosi_o (mosi),
    .spi_miso_i (miso),
    .spi_cs0_o  (cs0)
  );

  // MISO source: 0 = loopback of MOSI, 1 = constant level, 2 = bit pattern indexed by SCK rises.
  logic [1:0]  miso_mode = 2'd0;
  logic        miso_const = 1'b0;
  logic [7:0]  miso_pat = 8'h00;
  int          rise_base = 0;
  int          rises_total = 0;
  int          pat_idx;
  logic        pat_bit;
  assign pat_idx = rises_total - rise_base;
  assign pat_bit = (pat_idx >= 0 && pat_idx < 8) ? miso_pat[3'(7 - pat_idx)] : 1'b0;
  assign miso = (miso_mode == 2'd0) ? mosi : (miso_mode == 2'd1) ? miso_const : pat_bit;

  // Pin monitor: timestamps SCK edges in wb_clk cycles and records MOSI at each rise.
  int unsigned cyc_cnt = 0;
  int unsigned rise_cyc[$];
  int unsigned fall_cyc[$];
  logic        mosi_rise[$];
  logic        sck_prev = 1'b0;
  always @(posedge clk) begin
    cyc_cnt = cyc_cnt + 1;
    #1;
    if (sck === 1'b1 && sck_prev === 1'b0) begin
      rise_cyc.push_back(cyc_cnt);
      mosi_rise.push_back(mosi);
      rises_total = rises_total + 1;
    end
    if (sck === 1'b0 && sck_prev === 1'b1) fall_cyc.push_back(cyc_cnt);
    sck_prev = sck;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int unsigned last_ack_cyc;

  task automatic wb_access(input logic w, input logic [1:0] a, input logic [31:0] wd,
                           output logic [31:0] rd);
    int unsigned n;
    logic got;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = wd; sel = 4'hF;
    got = 1'b0; n = 0; rd = 'x;
    while (!got && n < 8) begin
      @(posedge clk); #1;
      n++;
      if (ack === 1'b1) begin
        got = 1'b1;
        rd = dat_r;
        last_ack_cyc = cyc_cnt;
      end
    end
    check("ack_latency", n, 1);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_pulse", {31'b0, ack}, 0);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_access(1'b1, a, wd, dummy);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] rd);
    wb_access(1'b0, a, 32'h0, rd);
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc_cnt < target) begin
      @(posedge clk); #1;
    end
  endtask

  // Transfer context shared between start_xfer and finish_xfer.
  logic [7:0]  x_tx;
  logic [7:0]  x_exp;
  int unsigned x_div;
  int unsigned x_s;
  int unsigned x_rb;
  int unsigned x_fb;

  task automatic start_xfer(input logic [7:0] tx, input int unsigned d, input logic [1:0] mode,
                            input logic [7:0] pat);
    logic [31:0] st;
    miso_mode = mode;
    miso_pat  = pat;
    rise_base = rises_total;
    x_tx  = tx;
    x_div = d;
    x_exp = (mode == 2'd0) ? tx : (mode == 2'd1) ? {8{miso_const}} : pat;
    x_rb  = rise_cyc.size();
    x_fb  = fall_cyc.size();
    wb_write(ADR_TXRX, {24'b0, tx});
    x_s = last_ack_cyc;
    wb_read(ADR_STATUS, st);
    check("busy_after_start", {31'b0, st[ST_BUSY]}, 1);
  endtask

  task automatic finish_xfer(input string tag);
    logic [31:0] st;
    logic [31:0] rd;
    int unsigned bad;
    logic [7:0]  mb;
    wait_cyc(x_s + 16 * (x_div + 1) + 2);
    check({tag, "_rises"}, rise_cyc.size() - x_rb, 8);
    check({tag, "_falls"}, fall_cyc.size() - x_fb, 8);
    bad = 0;
    mb  = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (x_rb + k < rise_cyc.size()) begin
        if (rise_cyc[x_rb + k] != x_s + (2 * k + 1) * (x_div + 1)) bad++;
        mb = {mb[6:0], mosi_rise[x_rb + k]};
      end else bad++;
      if (x_fb + k < fall_cyc.size()) begin
        if (fall_cyc[x_fb + k] != x_s + (2 * k + 2) * (x_div + 1)) bad++;
      end else bad++;
    end
    check({tag, "_edge_timing"}, bad, 0);
    check({tag, "_mosi_bits"}, {24'b0, mb}, {24'b0, x_tx});
    check({tag, "_mosi_hold"}, {31'b0, mosi}, {31'b0, x_tx[0]});
    check({tag, "_sck_idle"}, {31'b0, sck}, 0);
    wb_read(ADR_STATUS, st);
    check({tag, "_status_done"}, {30'b0, st[1:0]}, 32'h2);
    wb_read(ADR_TXRX, rd);
    check({tag, "_rx"}, rd, {24'b0, x_exp});
    wb_read(ADR_STATUS, st);
    check({tag, "_done_cleared"}, {30'b0, st[1:0]}, 32'h0);
  endtask

  logic [31:0] r;
  int unsigned e;
  int unsigned d_rand;
  logic        cs_rand;

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0; sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", {31'b0, sck}, 0);
    check("rst_mosi", {31'b0, mosi}, 0);
    check("rst_cs0", {31'b0, cs0}, 1);
    check("rst_ack", {31'b0, ack}, 0);
    check("rst_dat", dat_r, 0);
    @(negedge clk); rst_n = 1'b1;
    wb_read(ADR_STATUS, r); check("rst_status", r, 0);
    wb_read(ADR_DIV, r);    check("rst_div", r, 11);
    wb_read(ADR_CS, r);     check("rst_cs_reg", r, 1);
    wb_read(ADR_TXRX, r);   check("rst_rx", r, 0);

    // Fastest SCK with loopback.
    wb_write(ADR_DIV, 32'h0);
    wb_write(ADR_CS, 32'h0);
    check("cs0_low", {31'b0, cs0}, 0);
    start_xfer(8'hA5, 0, 2'd0, 8'h00);
    finish_xfer("div0_a5");

    // DIV=3, MISO tied high.
    miso_const = 1'b1;
    wb_write(ADR_DIV, 32'h3);
    start_xfer(8'h3C, 3, 2'd1, 8'h00);
    finish_xfer("div3_3c");

    // Overrun: second write while busy is dropped.
    wb_write(ADR_DIV, 32'h1);
    start_xfer(8'h55, 1, 2'd0, 8'h00);
    wb_write(ADR_TXRX, 32'h11);
    wb_read(ADR_STATUS, r); check("ovr_set", r, 32'h5);
    finish_xfer("ovr_55");
    wb_read(ADR_STATUS, r); check("ovr_sticky", r, 32'h4);
    wb_write(ADR_STATUS, 32'h3);
    wb_read(ADR_STATUS, r); check("ovr_kept_bit2_0", r, 32'h4);
    wb_write(ADR_STATUS, 32'h4);
    wb_read(ADR_STATUS, r); check("ovr_cleared", r, 32'h0);

    // DIV changed mid-transfer applies to the next transfer only.
    start_xfer(8'h96, 1, 2'd2, 8'h6B);
    wb_write(ADR_DIV, 32'h7);
    wb_read(ADR_DIV, r); check("div_readback", r, 7);
    finish_xfer("div_mid_old");
    start_xfer(8'h4E, 7, 2'd2, 8'hD2);
    finish_xfer("div_mid_new");

    // TXRX read whose ack edge coincides with done being set.
    wb_write(ADR_DIV, 32'h1);
    start_xfer(8'hC7, 1, 2'd0, 8'h00);
    e = x_s + 32;
    wait_cyc(e - 1);
    wb_read(ADR_TXRX, r);
    check("race_rd_align", last_ack_cyc, e);
    finish_xfer("race_rd");

    // TXRX write on the busy-falling edge counts as overrun, no restart.
    wb_write(ADR_DIV, 32'h0);
    start_xfer(8'h81, 0, 2'd0, 8'h00);
    e = x_s + 16;
    wait_cyc(e - 1);
    wb_write(ADR_TXRX, 32'hFF);
    check("race_wr_align", last_ack_cyc, e);
    finish_xfer("race_wr");
    check("race_wr_no_restart", rise_cyc.size() - x_rb, 8);
    wb_read(ADR_STATUS, r); check("race_wr_ovr", r, 32'h4);
    wb_write(ADR_STATUS, 32'h4);

    // Randomized transfers against the pattern model.
    for (int i = 0; i < 6; i++) begin
      d_rand  = $urandom_range(0, 3);
      cs_rand = 1'($urandom_range(0, 1));
      wb_write(ADR_CS, {31'b0, cs_rand});
      check("rand_cs_pin", {31'b0, cs0}, {31'b0, cs_rand});
      wb_read(ADR_CS, r); check("rand_cs_reg", r, {31'b0, cs_rand});
      wb_write(ADR_DIV, d_rand);
      start_xfer(8'($urandom), d_rand, 2'd2, 8'($urandom));
      finish_xfer("rand");
    end

    // Asynchronous reset in the middle of bit 4.
    wb_write(ADR_DIV, 32'h3);
    wb_write(ADR_CS, 32'h0);
    start_xfer(8'hC3, 3, 2'd0, 8'h00);
    wait_cyc(x_s + 29);
    check("pre_rst_sck_high", {31'b0, sck}, 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midrst_sck", {31'b0, sck}, 0);
    check("midrst_cs0", {31'b0, cs0}, 1);
    check("midrst_mosi", {31'b0, mosi}, 0);
    @(negedge clk); rst_n = 1'b1;
    x_rb = rise_cyc.size();
    wb_read(ADR_STATUS, r); check("midrst_status", r, 0);
    wb_read(ADR_DIV, r);    check("midrst_div", r, 11);
    wb_read(ADR_CS, r);     check("midrst_cs_reg", r, 1);
    wb_read(ADR_TXRX, r);   check("midrst_rx", r, 0);
    repeat (20) @(posedge clk);
    #2;
    check("midrst_no_sck", rise_cyc.size() - x_rb, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
